apb_slave_mem: RTL and testbench

APB completer with a word-addressed register memory and a fixed number of wait states per transfer. It sits directly downstream of the APB bridge/requester on the shared APB bus. It consumes `pselx`/`penable`/`pwrite`/`paddr`/`pwdata` and returns `pready`/`prdata`/`pslverr`. The requester forwards `prdata`/`pslverr` to the bridge as read data and transfer error.

---
 rtl/apb_slave_mem_if.sv | 37 +++
 rtl/apb_slave_mem.sv | 135 +++++++++++++
 tb/tb_apb_slave_mem.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between requester and apb_slave_mem; pstrb exists only with APB_SLAVE_MEM_PSTRB_EN
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_SLAVE_MEM_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;
`endif
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

`ifdef APB_SLAVE_MEM_PSTRB_EN
    modport master (
        output pselx, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );
    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
`else
    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );
    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
`endif
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with word-addressed memory and fixed wait states
// Byte-strobe writes are enabled by defining APB_SLAVE_MEM_PSTRB_EN.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           pclk,
    input  logic           preset,
    apb_slave_mem_if.slave apb
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
`ifdef APB_SLAVE_MEM_PSTRB_EN
    logic [STRB_WIDTH-1:0] strb_q;
`endif
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  load, commit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_write, cur_err;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // In IDLE the bus carries the setup values; afterwards only the latched copy is trusted.
    always_comb begin
        cur_addr  = (state == IDLE) ? apb.paddr  : addr_q;
        cur_write = (state == IDLE) ? apb.pwrite : write_q;
        cur_err   = ({1'b0, cur_addr} >= DEPTH_LIMIT);
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (apb.pselx && !apb.penable) begin
                    load    = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!apb.pselx) begin
                    state_d = IDLE;
                end else if (apb.penable) begin
                    cnt_d = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                state_d = IDLE;
                commit  = apb.pselx && apb.penable && write_q && !err_q;
            end
            default: state_d = IDLE;
        endcase

        pready_d  = (state_d == READY);
        pslverr_d = (state_d == READY) && cur_err;
        prdata_d  = '0;
        if ((state_d == READY) && !cur_write && !cur_err) begin
            prdata_d = mem[cur_addr[IDX_WIDTH-1:0]];
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_SLAVE_MEM_PSTRB_EN
            strb_q    <= '0;
`endif
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            if (load) begin
                addr_q  <= apb.paddr;
                write_q <= apb.pwrite;
                wdata_q <= apb.pwdata;
                err_q   <= cur_err;
`ifdef APB_SLAVE_MEM_PSTRB_EN
                strb_q  <= apb.pstrb;
`endif
            end
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
`ifdef APB_SLAVE_MEM_PSTRB_EN
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (strb_q[b]) begin
                    mem[addr_q[IDX_WIDTH-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
`else
            mem[addr_q[IDX_WIDTH-1:0]] <= wdata_q;
`endif
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem with WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
module tb_apb_slave_mem;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int DEPTH = 64;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
`ifdef APB_SLAVE_MEM_PSTRB_EN
    logic [SW-1:0] strb = '1;
`endif

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .pclk(pclk), .preset(preset), .apb(bus1)
    );
    apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .apb(bus0)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
        int            id;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic mon(input int w);
        exp_t          e;
        logic [DW-1:0] d;
        logic          er;
        bit            empty;
        d     = (w == 1) ? bus1.prdata : bus0.prdata;
        er    = (w == 1) ? bus1.pslverr : bus0.pslverr;
        empty = (w == 1) ? (q1.size() == 0) : (q0.size() == 0);
        checks++;
        if (empty) begin
            failures++;
            $display("FAIL spurious_pready dut%0d actual=pready@%0d required=no_pready", w, cyc);
        end else begin
            if (w == 1) e = q1.pop_front();
            else        e = q0.pop_front();
            if (d !== e.data || er !== e.err || cyc != e.cyc) begin
                failures++;
                $display("FAIL xfer%0d dut%0d actual data=%h err=%b cycle=%0d required data=%h err=%b cycle=%0d",
                         e.id, w, d, er, cyc, e.data, e.err, e.cyc);
            end
        end
    endtask

    always @(negedge pclk) begin
        if (bus1.pready === 1'b1) mon(1);
        if (bus0.pready === 1'b1) mon(0);
    end

    task automatic drive(input int w, input logic sel, input logic en, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (w == 1) begin
            bus1.pselx = sel; bus1.penable = en; bus1.pwrite = wr; bus1.paddr = a; bus1.pwdata = d;
`ifdef APB_SLAVE_MEM_PSTRB_EN
            bus1.pstrb = strb;
`endif
        end else begin
            bus0.pselx = sel; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = d;
`ifdef APB_SLAVE_MEM_PSTRB_EN
            bus0.pstrb = strb;
`endif
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Access-phase address/data are scrambled on purpose: the DUT must use the setup values.
    task automatic xfer(input int w, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_d, input logic exp_err, input int id);
        exp_t e;
        bit   done;
        drive(1 - w, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(w, 1'b1, 1'b0, wr, a, d);
        e.data = exp_d;
        e.err  = exp_err;
        e.cyc  = cyc + 1 + ((w == 1) ? 1 : 0);
        e.id   = id;
        if (w == 1) q1.push_back(e);
        else        q0.push_back(e);
        @(posedge pclk); #1;
        drive(w, 1'b1, 1'b1, wr, ~a, ~d);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            done = (w == 1) ? bus1.pready : bus0.pready;
            @(posedge pclk); #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout xfer%0d dut%0d actual=no_pready required=pready_within_40", id, w);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=time_expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        idle_all();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_pready1", {31'b0, bus1.pready}, 32'h0);
        chk("reset_pslverr1", {31'b0, bus1.pslverr}, 32'h0);
        chk("reset_prdata1", bus1.prdata, 32'h0);
        chk("reset_pready0", {31'b0, bus0.pready}, 32'h0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // reset during WAIT of a write: nothing commits, memory cleared
        xfer(1, 1'b1, 8'd3, 32'h12345678, 32'h0, 1'b0, 1);
        xfer(1, 1'b0, 8'd3, 32'h0, 32'h12345678, 1'b0, 2);
        drive(1, 1'b1, 1'b0, 1'b1, 8'd3, 32'hDEADBEEF);
        @(posedge pclk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 8'd3, 32'hDEADBEEF);
        #2 preset = 1'b1;
        #1;
        chk("rst_wait_pready", {31'b0, bus1.pready}, 32'h0);
        chk("rst_wait_prdata", bus1.prdata, 32'h0);
        chk("rst_wait_pslverr", {31'b0, bus1.pslverr}, 32'h0);
        idle_all();
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'd3, 32'h0, 32'h0, 1'b0, 3);

        // reset while pready/prdata are high clears them immediately
        xfer(0, 1'b1, 8'd9, 32'h5555AAAA, 32'h0, 1'b0, 4);
        xfer(0, 1'b0, 8'd9, 32'h0, 32'h5555AAAA, 1'b0, 5);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'd9, 32'h0);
        @(posedge pclk); #1;
        drive(0, 1'b1, 1'b1, 1'b0, 8'd9, 32'h0);
        #1;
        chk("ready_before_reset", {31'b0, bus0.pready}, 32'h1);
        preset = 1'b1;
        #1;
        chk("rst_ready_pready", {31'b0, bus0.pready}, 32'h0);
        chk("rst_ready_prdata", bus0.prdata, 32'h0);
        idle_all();
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'd9, 32'h0, 32'h0, 1'b0, 6);

        // basic write/read with one wait state
        xfer(1, 1'b1, 8'd5, 32'hA5A51234, 32'h0, 1'b0, 10);
        xfer(1, 1'b0, 8'd5, 32'h0, 32'hA5A51234, 1'b0, 11);

        // out of range: address 64 must not alias onto word 0
        xfer(1, 1'b1, 8'd0, 32'h0BADF00D, 32'h0, 1'b0, 12);
        xfer(1, 1'b1, 8'd64, 32'h11111111, 32'h0, 1'b1, 13);
        xfer(1, 1'b0, 8'd64, 32'h0, 32'h0, 1'b1, 14);
        xfer(1, 1'b0, 8'd0, 32'h0, 32'h0BADF00D, 1'b0, 15);
        xfer(1, 1'b0, 8'd255, 32'h0, 32'h0, 1'b1, 16);

        // zero wait states, back-to-back
        s = cyc;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b1, 8'(i), 32'hC0DE0000 + i, 32'h0, 1'b0, 20 + i);
        end
        chk("b2b_cycles", 32'(cyc - s), 32'd8);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, 8'(i), 32'h0, 32'hC0DE0000 + i, 1'b0, 24 + i);
        end

        // abort during WAIT
        xfer(1, 1'b1, 8'd7, 32'h77770007, 32'h0, 1'b0, 30);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b1, 8'd7, 32'hFFFF0000);
        @(posedge pclk); #1;
        drive(1, 1'b0, 1'b1, 1'b1, 8'd7, 32'hFFFF0000);
        repeat (3) @(posedge pclk);
        #1;
        chk("abort_no_pready", {31'b0, bus1.pready}, 32'h0);
        xfer(1, 1'b0, 8'd7, 32'h0, 32'h77770007, 1'b0, 31);

        // access phase without setup is ignored
        drive(1, 1'b1, 1'b1, 1'b1, 8'd8, 32'hDEAD0008);
        repeat (3) @(posedge pclk);
        #1;
        chk("nosetup_no_pready", {31'b0, bus1.pready}, 32'h0);
        xfer(1, 1'b0, 8'd8, 32'h0, 32'h0, 1'b0, 32);

`ifdef APB_SLAVE_MEM_PSTRB_EN
        strb = 4'b1111;
        xfer(1, 1'b1, 8'd2, 32'h11223344, 32'h0, 1'b0, 40);
        strb = 4'b0101;
        xfer(1, 1'b1, 8'd2, 32'hAABBCCDD, 32'h0, 1'b0, 41);
        strb = 4'b0000;
        xfer(1, 1'b0, 8'd2, 32'h0, 32'h11BB33DD, 1'b0, 42);
        xfer(1, 1'b1, 8'd2, 32'hFFFFFFFF, 32'h0, 1'b0, 43);
        strb = 4'b1111;
        xfer(1, 1'b0, 8'd2, 32'h0, 32'h11BB33DD, 1'b0, 44);
`endif

        idle_all();
        repeat (5) @(posedge pclk);
        #1;
        chk("scoreboard_drained", 32'(q1.size() + q0.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
